// File: rtl/message_counter_pkg.sv
// Shared types and defaults for the multi-lane message counter.
// Optional feature macro: MESSAGE_COUNTER_OFFSET_EN (see message_counter_multi).
package message_counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefWidth      = 64;
    localparam int unsigned DefRegionBits = 16;
    localparam int unsigned DefLanes      = 4;

    // Number of low counter bits that select a lane within one beat.
    function automatic int unsigned lane_bits(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/message_counter_lane_gen.sv
// Combinational lane expansion: turns the registered base/range into LANES
// counter values {region, base+i} and their in-range flags.
// Optional feature macro: MESSAGE_COUNTER_OFFSET_EN (handled by the top; here
// the lower bound is always compared, and is zero when the feature is off).
module message_counter_lane_gen #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned REGION_BITS = 16,
    parameter int unsigned LANES       = 4
) (
    input  logic                          en,
    input  logic [REGION_BITS-1:0]        region,
    input  logic [WIDTH-REGION_BITS-1:0]  base,
    input  logic [WIDTH-REGION_BITS-1:0]  first,
    input  logic [WIDTH-REGION_BITS-1:0]  limit,
    output logic [LANES*WIDTH-1:0]        counter,
    output logic [LANES-1:0]              lane_valid
);

    localparam int unsigned CW = WIDTH - REGION_BITS;

    // base has its low lane bits cleared, so base+i never carries out of CW.
    always_comb begin
        counter    = '0;
        lane_valid = '0;
        if (en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                counter[i*WIDTH +: WIDTH] = {region, base + CW'(i)};
                lane_valid[i] = ((base + CW'(i)) >= first) && ((base + CW'(i)) <= limit);
            end
        end
    end

endmodule

// File: rtl/message_counter_multi.sv
// Multi-lane message counter: issues LANES consecutive {region, count} values
// per beat over an inclusive range, with valid/ready backpressure.
// Optional feature macro: MESSAGE_COUNTER_OFFSET_EN enables a programmable
// start offset; without it counting starts at zero and start_offset is ignored.
module message_counter_multi
    import message_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned REGION_BITS = DefRegionBits,
    parameter int unsigned LANES       = DefLanes
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic [REGION_BITS-1:0]        region_select,
    input  logic [WIDTH-REGION_BITS-1:0]  start_offset,
    input  logic [WIDTH-REGION_BITS-1:0]  limit,
    output logic [LANES*WIDTH-1:0]        counter,
    output logic [LANES-1:0]              lane_valid,
    output logic                          valid,
    input  logic                          ready,
    output logic                          done
);

    localparam int unsigned CW = WIDTH - REGION_BITS;
    localparam int unsigned LB = lane_bits(LANES);
    localparam logic [CW-1:0] LaneMask = CW'((1 << LB) - 1);
    localparam logic [CW-1:0] LaneStep = CW'(LANES);

    state_e                 state_q, state_d;
    logic [CW-1:0]          base_q;
    logic [CW-1:0]          limit_q;
    logic [CW-1:0]          first_q;
    logic [REGION_BITS-1:0] region_q;
    logic                   err_q;
    logic [CW-1:0]          first_d;
    logic [CW-1:0]          last_base;
    logic                   last_beat;

`ifdef MESSAGE_COUNTER_OFFSET_EN
    assign first_d = start_offset;
`else
    logic unused_start_offset;
    assign unused_start_offset = ^start_offset;
    assign first_d = '0;
`endif

    assign last_base = limit_q & ~LaneMask;
    // An inverted range (limit below first) still ends after one masked beat.
    assign last_beat = (base_q == last_base) || err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything but reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (ready && last_beat) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
        end
    end

    // Run parameters latched on start; base advances on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            limit_q  <= '0;
            first_q  <= '0;
            region_q <= '0;
            err_q    <= 1'b0;
        end else if (clear) begin
            base_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        region_q <= region_select;
                        limit_q  <= limit;
                        first_q  <= first_d;
                        base_q   <= first_d & ~LaneMask;
                        err_q    <= (limit < first_d);
                    end
                end
                StRun: begin
                    // Completion is tested before the increment so base never wraps.
                    if (ready && !last_beat) begin
                        base_q <= base_q + LaneStep;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        valid = (state_q == StRun);
        done  = (state_q == StDone);
    end

    message_counter_lane_gen #(
        .WIDTH       (WIDTH),
        .REGION_BITS (REGION_BITS),
        .LANES       (LANES)
    ) u_lane_gen (
        .en         (valid),
        .region     (region_q),
        .base       (base_q),
        .first      (first_q),
        .limit      (limit_q),
        .counter    (counter),
        .lane_valid (lane_valid)
    );

endmodule

// File: tb/tb_message_counter_multi.sv
// Directed bench for message_counter_multi: a vector table of complete runs
// plus hand-written backpressure, clear and wide-range sequences.
module tb_message_counter_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, clear, ready;
    logic [15:0]   region;
    logic [47:0]   offset, limit;
    logic [255:0]  counter;
    logic [3:0]    lane_valid;
    logic          valid, done;

    logic          start2, clear2;
    logic [7:0]    region2;
    logic [11:0]   offset2, limit2;
    logic [79:0]   counter2;
    logic [3:0]    lane_valid2;
    logic          valid2, done2;

    message_counter_multi dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear         (clear),
        .region_select (region),
        .start_offset  (offset),
        .limit         (limit),
        .counter       (counter),
        .lane_valid    (lane_valid),
        .valid         (valid),
        .ready         (ready),
        .done          (done)
    );

    message_counter_multi #(
        .WIDTH       (20),
        .REGION_BITS (8),
        .LANES       (4)
    ) dut_wide (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .clear         (clear2),
        .region_select (region2),
        .start_offset  (offset2),
        .limit         (limit2),
        .counter       (counter2),
        .lane_valid    (lane_valid2),
        .valid         (valid2),
        .ready         (ready),
        .done          (done2)
    );

    typedef struct {
        logic [15:0] region;
        logic [47:0] offset;
        logic [47:0] limit;
        int          nbeats;
        logic [47:0] base0;
        logic [3:0]  lv_first;
        logic [3:0]  lv_last;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_beat(input logic [15:0] r, input logic [47:0] b);
        logic [255:0] x;
        for (int i = 0; i < 4; i++) begin
            x[i*64 +: 64] = {r, b + 48'(i)};
        end
        return x;
    endfunction

    task automatic check_beat(input string name, input logic [15:0] r, input logic [47:0] b,
                              input logic [3:0] lv);
        check({name, " valid"}, {255'd0, valid}, 256'd1);
        check({name, " counter"}, counter, exp_beat(r, b));
        check({name, " lane_valid"}, {252'd0, lane_valid}, {252'd0, lv});
    endtask

    initial begin
        logic [3:0]  lv;
        int          beats2, errs2;
        logic [11:0] last2;

        vecs[0] = '{16'hABCD, 48'd0, 48'd7,  2, 48'd0, 4'hF, 4'hF};
        vecs[1] = '{16'h5555, 48'd0, 48'd9,  3, 48'd0, 4'hF, 4'h3};
        vecs[2] = '{16'h0001, 48'd0, 48'd0,  1, 48'd0, 4'h1, 4'h1};
`ifdef MESSAGE_COUNTER_OFFSET_EN
        vecs[3] = '{16'h0C0C, 48'd6, 48'd9,  2, 48'd4, 4'hC, 4'h3};
        vecs[4] = '{16'hE770, 48'd6, 48'd2,  1, 48'd4, 4'h0, 4'h0};
`else
        vecs[3] = '{16'h0C0C, 48'd6, 48'd9,  3, 48'd0, 4'hF, 4'h3};
        vecs[4] = '{16'hE770, 48'd6, 48'd2,  1, 48'd0, 4'h7, 4'h7};
`endif
        vecs[5] = '{16'h4242, 48'd0, 48'd14, 4, 48'd0, 4'hF, 4'h7};

        rst = 1'b1; start = 1'b0; clear = 1'b0; ready = 1'b1;
        region = '0; offset = '0; limit = '0;
        start2 = 1'b0; clear2 = 1'b0; region2 = '0; offset2 = '0; limit2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset valid", {255'd0, valid}, 256'd0);
        check("reset done", {255'd0, done}, 256'd0);
        check("reset counter", counter, 256'd0);
        check("reset lane_valid", {252'd0, lane_valid}, 256'd0);
        check("reset wide counter", {176'd0, counter2}, 256'd0);

        // Table of complete runs with ready held high.
        for (int v = 0; v < NV; v++) begin
            region = vecs[v].region; offset = vecs[v].offset; limit = vecs[v].limit;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < vecs[v].nbeats; k++) begin
                lv = (k == 0) ? vecs[v].lv_first :
                     (k == vecs[v].nbeats - 1) ? vecs[v].lv_last : 4'hF;
                check_beat($sformatf("vec%0d beat%0d", v, k), vecs[v].region,
                           vecs[v].base0 + 48'(4 * k), lv);
                @(negedge clk);
            end
            check($sformatf("vec%0d done", v), {255'd0, done}, 256'd1);
            check($sformatf("vec%0d valid off", v), {255'd0, valid}, 256'd0);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            check($sformatf("vec%0d cleared", v), {254'd0, done, valid}, 256'd0);
        end

        // Backpressure on beat 2: values must hold for three stalled cycles.
        region = 16'h00BB; offset = '0; limit = 48'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_beat("bp beat0", 16'h00BB, 48'd0, 4'hF);
        @(negedge clk);
        ready = 1'b0;
        check_beat("bp beat1", 16'h00BB, 48'd4, 4'hF);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_beat($sformatf("bp hold%0d", j), 16'h00BB, 48'd4, 4'hF);
        end
        ready = 1'b1;
        @(negedge clk);
        check_beat("bp beat2", 16'h00BB, 48'd8, 4'h3);
        @(negedge clk);
        check("bp done", {255'd0, done}, 256'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Clear mid-run, then restart immediately.
        region = 16'h7777; limit = 48'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_beat("clr beat0", 16'h7777, 48'd0, 4'hF);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr valid drop", {254'd0, done, valid}, 256'd0);
        region = 16'h1234; limit = 48'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_beat("restart beat0", 16'h1234, 48'd0, 4'hF);
        @(negedge clk);
        check("restart done", {255'd0, done}, 256'd1);
        region = 16'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start in done ignored", {254'd0, done, valid}, 256'd2);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check("clear+start idle", {254'd0, done, valid}, 256'd0);
        @(negedge clk);
        check("clear+start no run", {254'd0, done, valid}, 256'd0);

        // Full-range run on the narrow instance: ends at 0xFFC, never wraps.
        region2 = 8'h5A; limit2 = 12'hFFF; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        beats2 = 0; errs2 = 0; last2 = '0;
        for (int c = 0; c < 3000 && !done2; c++) begin
            if (valid2) begin
                if (counter2[19:0] !== {8'h5A, 12'(beats2 * 4)}) errs2++;
                last2 = counter2[11:0];
                beats2++;
            end
            @(negedge clk);
        end
        check("wide done", {255'd0, done2}, 256'd1);
        check("wide beats", 256'(beats2), 256'd1024);
        check("wide last base", {244'd0, last2}, 256'hFFC);
        check("wide sequence errors", 256'(errs2), 256'd0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("wide no wrap %0d", j), {254'd0, done2, valid2}, 256'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
